// File: rtl/risc_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states
// and the default data/address widths.
package risc_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int ADDR_W_DEF = 32;

   typedef enum logic [1:0] {
      SZ_BYTE   = 2'b00,
      SZ_HALF   = 2'b01,
      SZ_WORD   = 2'b10,
      SZ_DOUBLE = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_WAIT = 2'b10,
      S_DONE = 2'b11
   } state_e;

   // A double access cannot exist on a 32-bit datapath; treat it as a word.
   function automatic size_e clamp_size(input size_e sz, input int xlen);
      if (xlen == 32 && sz == SZ_DOUBLE) return SZ_WORD;
      return sz;
   endfunction

endpackage

// File: rtl/risc_lsu_if.sv
// Memory-side request/response bus of the load/store unit.
// master = LSU, slave = RAM.
interface risc_lsu_if #(
   parameter int XLEN   = risc_pkg::XLEN_DEF,
   parameter int ADDR_W = risc_pkg::ADDR_W_DEF
);

   logic              ram_req_valid;
   logic              ram_req_ready;
   logic              ram_req_we;
   logic [ADDR_W-1:0] ram_req_addr;
   logic [XLEN-1:0]   ram_req_wdata;
   logic [XLEN/8-1:0] ram_req_be;
   logic              ram_rsp_valid;
   logic [XLEN-1:0]   ram_rsp_data;

   modport master (
      output ram_req_valid, ram_req_we, ram_req_addr, ram_req_wdata, ram_req_be,
      input  ram_req_ready, ram_rsp_valid, ram_rsp_data
   );

   modport slave (
      input  ram_req_valid, ram_req_we, ram_req_addr, ram_req_wdata, ram_req_be,
      output ram_req_ready, ram_rsp_valid, ram_rsp_data
   );

endinterface

// File: rtl/risc_lsu_align.sv
// Lane logic for the load/store unit: byte enables, store-data lane
// replication, load-data extraction and sign/zero extension. Purely
// combinational; the offset is truncated to natural alignment here.
module risc_lsu_align
   import risc_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  size_e                      size_i,
   input  logic [$clog2(XLEN/8)-1:0]  off_i,
   input  logic                       unsigned_i,
   input  logic [XLEN-1:0]            wdata_i,
   input  logic [XLEN-1:0]            rdata_i,
   output logic [XLEN/8-1:0]          be_o,
   output logic [XLEN-1:0]            wdata_o,
   output logic [XLEN-1:0]            rdata_o
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   size_e             sz_eff;
   logic [OFF_W-1:0]  off_eff;
   logic [NB-1:0]     mask;
   logic [XLEN-1:0]   shifted;
   logic [XLEN-1:0]   keep;
   logic              sbit;

   // Effective size, aligned lane offset and the lane mask it selects.
   always_comb begin
      sz_eff  = clamp_size(size_i, XLEN);
      off_eff = off_i & ~OFF_W'((32'd1 << sz_eff) - 32'd1);
      mask    = NB'((32'd1 << (32'd1 << sz_eff)) - 32'd1);
      be_o    = mask << off_eff;
   end

   // Replicate the low bytes of the store data across every lane.
   always_comb begin
      wdata_o = '0;
      for (int i = 0; i < NB; i++) begin
         case (sz_eff)
            SZ_BYTE: wdata_o[i*8 +: 8] = wdata_i[7:0];
            SZ_HALF: wdata_o[i*8 +: 8] = wdata_i[(i%2)*8 +: 8];
            SZ_WORD: wdata_o[i*8 +: 8] = wdata_i[(i%4)*8 +: 8];
            default: wdata_o[i*8 +: 8] = wdata_i[i*8 +: 8];
         endcase
      end
   end

   // Shift the addressed lane down, keep the access width, then extend.
   always_comb begin
      shifted = rdata_i >> {off_eff, 3'b000};
      case (sz_eff)
         SZ_BYTE: begin keep = XLEN'(8'hFF);         sbit = shifted[7];      end
         SZ_HALF: begin keep = XLEN'(16'hFFFF);      sbit = shifted[15];     end
         SZ_WORD: begin keep = XLEN'(32'hFFFF_FFFF); sbit = shifted[31];     end
         default: begin keep = '1;                   sbit = shifted[XLEN-1]; end
      endcase
      sbit    = sbit & ~unsigned_i;
      rdata_o = (shifted & keep) | ({XLEN{sbit}} & ~keep);
   end

endmodule

// File: rtl/risc_lsu.sv
// Load/store unit for the MEM stage: captures one memory op, issues a single
// lane-aligned RAM request, waits (bounded) for load data and writes back.
// Optional macro RISC_LSU_MISALIGN_TRAP_EN: misaligned accesses are not
// issued and are reported on err_misalign instead.
module risc_lsu
   import risc_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic              ex_load,
   input  logic              ex_store,
   input  logic              ex_unsigned,
   input  logic [1:0]        ex_size,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [XLEN-1:0]   ex_wdata,
   input  logic [4:0]        ex_rd,
   output logic              lsu_busy,
   risc_lsu_if.master        ram,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [XLEN-1:0]   wb_data,
   output logic              err_misalign,
   output logic              err_timeout
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e            state_q;
   logic              req_valid_q;
   logic              wb_valid_q;
   logic              err_timeout_q;
   logic [XLEN-1:0]   wb_data_q;
   logic [4:0]        wb_rd_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              load_q;
   logic              unsigned_q;
   size_e             size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [4:0]        rd_q;

   logic              take;
   logic [NB-1:0]     be;
   logic [XLEN-1:0]   wdata_rep;
   logic [XLEN-1:0]   rdata_ext;

   assign take = (state_q == S_IDLE) && ex_valid && (ex_load || ex_store);

`ifdef RISC_LSU_MISALIGN_TRAP_EN
   logic err_misalign_q;
   logic ex_misaligned;

   // Address must be a multiple of the access size; double needs a 64-bit bus.
   always_comb begin
      case (size_e'(ex_size))
         SZ_BYTE: ex_misaligned = 1'b0;
         SZ_HALF: ex_misaligned = ex_addr[0];
         SZ_WORD: ex_misaligned = |ex_addr[1:0];
         default: ex_misaligned = (XLEN == 32) ? 1'b1 : |ex_addr[2:0];
      endcase
   end

   assign err_misalign = err_misalign_q;
`else
   assign err_misalign = 1'b0;
`endif

   // Operation capture; only loaded when a new op is accepted in IDLE.
   always_ff @(posedge clk) begin
      if (take) begin
         load_q     <= ex_load;
         unsigned_q <= ex_unsigned;
         size_q     <= size_e'(ex_size);
         addr_q     <= ex_addr;
         wdata_q    <= ex_wdata;
         rd_q       <= ex_rd;
      end
   end

   risc_lsu_align #(.XLEN(XLEN)) u_align (
      .size_i     (size_q),
      .off_i      (addr_q[OFF_W-1:0]),
      .unsigned_i (unsigned_q),
      .wdata_i    (wdata_q),
      .rdata_i    (ram.ram_rsp_data),
      .be_o       (be),
      .wdata_o    (wdata_rep),
      .rdata_o    (rdata_ext)
   );

   // Control FSM with registered handshake, writeback and error outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         req_valid_q   <= 1'b0;
         wb_valid_q    <= 1'b0;
         err_timeout_q <= 1'b0;
         wb_data_q     <= '0;
         wb_rd_q       <= '0;
         cnt_q         <= '0;
`ifdef RISC_LSU_MISALIGN_TRAP_EN
         err_misalign_q <= 1'b0;
`endif
      end else begin
         wb_valid_q    <= 1'b0;
         err_timeout_q <= 1'b0;
`ifdef RISC_LSU_MISALIGN_TRAP_EN
         err_misalign_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (take) begin
                  cnt_q <= '0;
`ifdef RISC_LSU_MISALIGN_TRAP_EN
                  if (ex_misaligned) begin
                     err_misalign_q <= 1'b1;
                     state_q        <= S_DONE;
                  end else
`endif
                  begin
                     req_valid_q <= 1'b1;
                     state_q     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (ram.ram_req_ready) begin
                  req_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= load_q ? S_WAIT : S_DONE;
               end
            end
            S_WAIT: begin
               if (ram.ram_rsp_valid) begin
                  wb_data_q  <= rdata_ext;
                  wb_rd_q    <= rd_q;
                  wb_valid_q <= 1'b1;
                  state_q    <= S_DONE;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  wb_data_q     <= '0;
                  err_timeout_q <= 1'b1;
                  state_q       <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign lsu_busy = rst_n && (take || state_q == S_REQ || state_q == S_WAIT);

   assign ram.ram_req_valid = req_valid_q;
   assign ram.ram_req_we    = ~load_q;
   assign ram.ram_req_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign ram.ram_req_wdata = wdata_rep;
   assign ram.ram_req_be    = be;

   assign wb_valid    = wb_valid_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_risc_lsu.sv
// Scoreboard bench for risc_lsu (XLEN=32, TIMEOUT=4): expected requests and
// writebacks are queued when an op is driven and compared when they appear.
module tb_risc_lsu;

   localparam int XLEN    = 32;
   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0, ex_unsigned = 1'b0;
   logic [1:0]  ex_size = 2'b00;
   logic [31:0] ex_addr = '0, ex_wdata = '0;
   logic [4:0]  ex_rd = '0;
   logic        lsu_busy, wb_valid, err_misalign, err_timeout;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        tmo;
   } wb_t;

   req_t req_q[$];
   wb_t  wb_q[$];

   risc_lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) ram ();

   risc_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_load      (ex_load),
      .ex_store     (ex_store),
      .ex_unsigned  (ex_unsigned),
      .ex_size      (ex_size),
      .ex_addr      (ex_addr),
      .ex_wdata     (ex_wdata),
      .ex_rd        (ex_rd),
      .lsu_busy     (lsu_busy),
      .ram          (ram),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .err_misalign (err_misalign),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference model of the lane logic (32-bit bus, offsets truncated).
   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      case (sz)
         2'b00:   m_be = 4'b0001 << a[1:0];
         2'b01:   m_be = a[1] ? 4'b1100 : 4'b0011;
         default: m_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] m_wrep(input logic [1:0] sz, input logic [31:0] w);
      case (sz)
         2'b00:   m_wrep = {4{w[7:0]}};
         2'b01:   m_wrep = {2{w[15:0]}};
         default: m_wrep = w;
      endcase
   endfunction

   function automatic logic [31:0] m_ext(input logic [31:0] r, input logic [1:0] sz,
                                         input logic [31:0] a, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      case (a[1:0])
         2'd0: b = r[7:0];
         2'd1: b = r[15:8];
         2'd2: b = r[23:16];
         default: b = r[31:24];
      endcase
      h = a[1] ? r[31:16] : r[15:0];
      case (sz)
         2'b00:   m_ext = uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   m_ext = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: m_ext = r;
      endcase
   endfunction

   // Drive one op, play the RAM side and check request and writeback.
   // rsp_dly < 0 means the RAM never answers. lat = cycles capture->wb.
   task automatic run_op(input logic ld, input logic st, input logic uns,
                         input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input int rdy_dly, input int rsp_dly,
                         input logic [31:0] rsp, output int lat);
      req_t r, got;
      wb_t  w, e;
      int   n, cap;
      lat = 0;
      r.we = ~ld;
      r.addr = {addr[31:2], 2'b00};
      r.be = m_be(sz, addr);
      r.wdata = m_wrep(sz, wdata);
      req_q.push_back(r);
      if (ld) begin
         w.rd = rd;
         w.tmo = (rsp_dly < 0);
         w.data = w.tmo ? 32'h0 : m_ext(rsp, sz, addr, uns);
         wb_q.push_back(w);
      end
      ram.ram_req_ready = (rdy_dly == 0);
      ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_unsigned = uns;
      ex_size = sz; ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
      #1;
      checks++;
      if (lsu_busy !== 1'b1) begin
         errors++; $display("FAIL busy_on_present got %b exp 1", lsu_busy);
      end
      tick;
      cap = cyc;
      ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
      ex_addr = 32'hDEAD_BEEF; ex_wdata = 32'h5A5A_5A5A; ex_size = 2'b11; ex_rd = 5'd31;
      for (int i = 0; i < rdy_dly; i++) begin
         checks++;
         if (ram.ram_req_valid !== 1'b1 || lsu_busy !== 1'b1 || ram.ram_req_addr !== r.addr ||
             ram.ram_req_be !== r.be || ram.ram_req_wdata !== r.wdata) begin
            errors++;
            $display("FAIL req_stall_hold cyc %0d got v=%b busy=%b a=%h be=%b d=%h exp a=%h be=%b d=%h",
                     i, ram.ram_req_valid, lsu_busy, ram.ram_req_addr, ram.ram_req_be,
                     ram.ram_req_wdata, r.addr, r.be, r.wdata);
         end
         tick;
      end
      ram.ram_req_ready = 1'b1;
      #1;
      got = req_q.pop_front();
      checks++;
      if (ram.ram_req_valid !== 1'b1 || ram.ram_req_we !== got.we || ram.ram_req_addr !== got.addr ||
          ram.ram_req_be !== got.be || ram.ram_req_wdata !== got.wdata) begin
         errors++;
         $display("FAIL req_fields got v=%b we=%b a=%h be=%b d=%h exp v=1 we=%b a=%h be=%b d=%h",
                  ram.ram_req_valid, ram.ram_req_we, ram.ram_req_addr, ram.ram_req_be,
                  ram.ram_req_wdata, got.we, got.addr, got.be, got.wdata);
      end
      tick;
      ram.ram_req_ready = 1'b0;
      if (!ld) begin
         checks++;
         if (wb_valid !== 1'b0 || lsu_busy !== 1'b0 || ram.ram_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_done got wb=%b busy=%b rv=%b exp 0 0 0", wb_valid, lsu_busy, ram.ram_req_valid);
         end
         tick;
         return;
      end
      if (rsp_dly >= 0) begin
         repeat (rsp_dly) tick;
         ram.ram_rsp_valid = 1'b1; ram.ram_rsp_data = rsp;
         tick;
         ram.ram_rsp_valid = 1'b0; ram.ram_rsp_data = ~rsp;
      end
      n = 0;
      while (wb_valid !== 1'b1 && err_timeout !== 1'b1 && n < 40) begin
         tick; n++;
      end
      e = wb_q.pop_front();
      checks++;
      if (n >= 40) begin
         errors++; $display("FAIL wb_wait got no completion exp completion within 40 cycles");
         return;
      end
      lat = cyc - cap + 1;
      if (wb_valid !== ~e.tmo || err_timeout !== e.tmo || wb_data !== e.data ||
          (!e.tmo && wb_rd !== e.rd)) begin
         errors++;
         $display("FAIL wb_result got v=%b to=%b d=%h rd=%0d exp v=%b to=%b d=%h rd=%0d",
                  wb_valid, err_timeout, wb_data, wb_rd, ~e.tmo, e.tmo, e.data, e.rd);
      end
      tick;
      checks++;
      if (wb_valid !== 1'b0 || err_timeout !== 1'b0 || err_misalign !== 1'b0 || lsu_busy !== 1'b0) begin
         errors++;
         $display("FAIL one_cycle_pulse got wb=%b to=%b mis=%b busy=%b exp 0 0 0 0",
                  wb_valid, err_timeout, err_misalign, lsu_busy);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      ex_valid = 1'b1; ex_load = 1'b1; ex_addr = 32'h100;
      ram.ram_rsp_valid = 1'b1; ram.ram_rsp_data = 32'hFFFF_FFFF;
      tick; tick;
      checks++;
      if (ram.ram_req_valid !== 1'b0 || wb_valid !== 1'b0 || err_misalign !== 1'b0 ||
          err_timeout !== 1'b0 || lsu_busy !== 1'b0 || wb_data !== 32'h0 || wb_rd !== 5'd0) begin
         errors++;
         $display("FAIL reset_state got rv=%b wb=%b mis=%b to=%b busy=%b d=%h rd=%0d exp all 0",
                  ram.ram_req_valid, wb_valid, err_misalign, err_timeout, lsu_busy, wb_data, wb_rd);
      end
      ex_valid = 1'b0; ex_load = 1'b0; ram.ram_rsp_valid = 1'b0;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_ignore;
      ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0;
      ram.ram_rsp_valid = 1'b1; ram.ram_rsp_data = 32'h1234_5678;
      #1;
      checks++;
      if (lsu_busy !== 1'b0) begin
         errors++; $display("FAIL ignore_busy got %b exp 0", lsu_busy);
      end
      tick; tick;
      checks++;
      if (ram.ram_req_valid !== 1'b0 || wb_valid !== 1'b0 || lsu_busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_nonmem got rv=%b wb=%b busy=%b exp 0 0 0", ram.ram_req_valid, wb_valid, lsu_busy);
      end
      ex_valid = 1'b0; ram.ram_rsp_valid = 1'b0;
   endtask

   task automatic test_store_byte;
      int lat;
      run_op(1'b0, 1'b1, 1'b0, 2'b00, 32'h1003, 32'h0000_00AB, 5'd0, 0, 0, 32'h0, lat);
   endtask

   task automatic test_load_signed_half;
      int lat;
      run_op(1'b1, 1'b0, 1'b0, 2'b01, 32'h2002, 32'h0, 5'd7, 0, 0, 32'h8001_1234, lat);
      checks++;
      if (lat != 3) begin
         errors++; $display("FAIL load_latency got %0d exp 3", lat);
      end
   endtask

   task automatic test_ready_stall;
      int lat;
      run_op(1'b1, 1'b0, 1'b1, 2'b00, 32'h4001, 32'h0, 5'd9, 4, 1, 32'h1234_F5AA, lat);
      checks++;
      if (lat != 8) begin
         errors++; $display("FAIL stall_latency got %0d exp 8", lat);
      end
   endtask

   task automatic test_timeout;
      int lat;
      run_op(1'b1, 1'b0, 1'b0, 2'b10, 32'h5000, 32'h0, 5'd3, 0, -1, 32'h0, lat);
      checks++;
      if (lat != 2 + TIMEOUT) begin
         errors++; $display("FAIL timeout_latency got %0d exp %0d", lat, 2 + TIMEOUT);
      end
   endtask

   task automatic test_misalign;
`ifdef RISC_LSU_MISALIGN_TRAP_EN
      ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_size = 2'b10; ex_addr = 32'h3002;
      tick;
      ex_valid = 1'b0; ex_load = 1'b0;
      checks++;
      if (ram.ram_req_valid !== 1'b0 || err_misalign !== 1'b1 || wb_valid !== 1'b0 || lsu_busy !== 1'b0) begin
         errors++;
         $display("FAIL misalign_trap got rv=%b mis=%b wb=%b busy=%b exp 0 1 0 0",
                  ram.ram_req_valid, err_misalign, wb_valid, lsu_busy);
      end
      tick;
      checks++;
      if (ram.ram_req_valid !== 1'b0 || err_misalign !== 1'b0) begin
         errors++;
         $display("FAIL misalign_pulse got rv=%b mis=%b exp 0 0", ram.ram_req_valid, err_misalign);
      end
`else
      int lat;
      run_op(1'b1, 1'b0, 1'b0, 2'b10, 32'h3002, 32'h0, 5'd4, 0, 0, 32'hCAFE_F00D, lat);
`endif
   endtask

   task automatic test_reset_in_wait;
      ram.ram_req_ready = 1'b1;
      ex_valid = 1'b1; ex_load = 1'b1; ex_size = 2'b10; ex_addr = 32'h6000; ex_rd = 5'd12;
      tick;
      ex_valid = 1'b0; ex_load = 1'b0;
      tick;
      ram.ram_req_ready = 1'b0;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      ram.ram_rsp_valid = 1'b1; ram.ram_rsp_data = 32'h7777_7777;
      tick;
      ram.ram_rsp_valid = 1'b0;
      checks++;
      if (wb_valid !== 1'b0 || lsu_busy !== 1'b0 || ram.ram_req_valid !== 1'b0 || wb_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_in_wait got wb=%b busy=%b rv=%b d=%h exp 0 0 0 0",
                  wb_valid, lsu_busy, ram.ram_req_valid, wb_data);
      end
      tick;
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++; $display("FAIL late_rsp got wb=%b exp 0", wb_valid);
      end
   endtask

   task automatic test_load_store_both;
      int lat;
      run_op(1'b1, 1'b1, 1'b0, 2'b00, 32'h7002, 32'h0000_0011, 5'd5, 0, 0, 32'h0080_0000, lat);
   endtask

   task automatic test_back_to_back;
      logic [1:0]  sz;
      logic [31:0] a;
      logic        ld, st;
      int          rdy, rsp, lat;
      for (int k = 0; k < 10; k++) begin
         sz  = 2'($urandom_range(0, 2));
         a   = $urandom & ~((32'd1 << sz) - 32'd1);
         ld  = 1'($urandom_range(0, 1));
         st  = ~ld | 1'($urandom_range(0, 1));
         rdy = $urandom_range(0, 2);
         rsp = $urandom_range(0, 2);
         run_op(ld, st, 1'($urandom_range(0, 1)), sz, a, $urandom, 5'($urandom_range(1, 31)),
                rdy, rsp, $urandom, lat);
         if (ld) begin
            checks++;
            if (lat != 3 + rdy + rsp) begin
               errors++; $display("FAIL b2b_latency op %0d got %0d exp %0d", k, lat, 3 + rdy + rsp);
            end
         end
      end
   endtask

   initial begin
      ram.ram_req_ready = 1'b0;
      ram.ram_rsp_valid = 1'b0;
      ram.ram_rsp_data  = '0;
      test_reset;
      test_ignore;
      test_store_byte;
      test_load_signed_half;
      test_ready_stall;
      test_timeout;
      test_misalign;
      test_reset_in_wait;
      test_load_store_both;
      test_back_to_back;
      checks++;
      if (req_q.size() != 0 || wb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got req=%0d wb=%0d exp 0 0", req_q.size(), wb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish exp finish before 200000");
      $fatal(1);
   end

endmodule
